// File: rtl/inv6_response_checker_pkg.sv
// Shared definitions for the hex-inverter response checker.
//   - state_t     : sequencer states
//   - NUM_VECTORS : number of stimulus vectors in one test sequence
//   - VEC_W       : width of the stimulus/response bus (six inverters)
//   - thermo_vec  : thermometer-coded stimulus for a given vector index
package inv6_response_checker_pkg;

    localparam int NUM_VECTORS = 7;
    localparam int VEC_W       = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Vector k drives A1..Ak high and the remaining inputs low (bit 0 = A1).
    function automatic logic [VEC_W-1:0] thermo_vec(input logic [2:0] idx);
        logic [VEC_W-1:0] v;
        for (int i = 0; i < VEC_W; i++) begin
            v[i] = (i < int'(idx));
        end
        return v;
    endfunction

endpackage

// File: rtl/inv6_response_checker_sync.sv
// Two-flop synchronizer for a bus of independent, slowly changing bits.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flop stages
//   d     : asynchronous input bus
//   q     : synchronized output bus (two clk cycles of latency)
module sync2_bus #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inv6_response_checker.sv
// Self-test sequencer for a hex inverter. On start it walks through seven
// thermometer-coded vectors, waits SETTLE_CYCLES after driving each one,
// then compares the synchronized inverter outputs against the inverted
// stimulus and accumulates per-bit and per-vector failure information.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle request to run a sequence (ignored while busy)
//   A1..A6     : stimulus to the inverter inputs
//   Y1..Y6     : inverter outputs, asynchronous to clk
//   busy       : sequence in progress
//   done       : sequence finished, results valid until the next start
//   pass       : every vector matched (valid while done)
//   err_count  : number of vectors with at least one mismatching bit
//   fail_mask  : bit i-1 set if Yi mismatched on any vector
module inv6_response_checker
    import inv6_response_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       A4,
    output logic       A5,
    output logic       A6,
    input  logic       Y1,
    input  logic       Y2,
    input  logic       Y3,
    input  logic       Y4,
    input  logic       Y5,
    input  logic       Y6,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [5:0] fail_mask
);

    localparam logic [2:0] LAST_IDX   = 3'(NUM_VECTORS - 1);
    localparam logic [3:0] SETTLE_END = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [2:0]       idx;
    logic [3:0]       cnt;
    logic [VEC_W-1:0] a_vec;
    logic [VEC_W-1:0] y_sync;
    logic [VEC_W-1:0] mismatch;
    logic [2:0]       err_next;

    sync2_bus #(
        .WIDTH(VEC_W)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({Y6, Y5, Y4, Y3, Y2, Y1}),
        .q    (y_sync)
    );

    // A healthy inverter returns the complement of the stimulus, so any bit
    // of y_sync that equals the stimulus bit is a failure.
    assign mismatch = y_sync ^ ~thermo_vec(idx);
    assign err_next = err_count + {2'b00, |mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            a_vec     <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_DRIVE;
                        idx       <= '0;
                        cnt       <= '0;
                        a_vec     <= thermo_vec(3'd0);
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_mask <= '0;
                    end
                end
                ST_DRIVE: begin
                    state <= ST_SETTLE;
                    cnt   <= '0;
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_END) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    fail_mask <= fail_mask | mismatch;
                    err_count <= err_next;
                    if (idx == LAST_IDX) begin
                        // Include the final vector's result in pass.
                        state <= ST_DONE;
                        pass  <= (err_next == 3'd0);
                    end else begin
                        state <= ST_DRIVE;
                        idx   <= idx + 3'd1;
                        a_vec <= thermo_vec(idx + 3'd1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);

    assign A1 = a_vec[0];
    assign A2 = a_vec[1];
    assign A3 = a_vec[2];
    assign A4 = a_vec[3];
    assign A5 = a_vec[4];
    assign A6 = a_vec[5];

endmodule

// File: tb/tb_inv6_response_checker.sv
// Directed bench for inv6_response_checker: one instance at SETTLE_CYCLES=4
// with selectable stuck-at faults on the inverter model, and one at
// SETTLE_CYCLES=2 driven by an ideal inverter.
module tb_inv6_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       start2;
    int         fault;

    logic [5:0] a4, y4, a2, y2;
    logic       busy4, done4, pass4, busy2, done2, pass2;
    logic [2:0] err4, err2;
    logic [5:0] mask4, mask2;

    int errors = 0;
    int checks = 0;

    // fault 0: ideal, 1: Y3 stuck at 1, 2: Y1 stuck at 0
    always_comb begin
        y4 = ~a4;
        if (fault == 1) y4[2] = 1'b1;
        if (fault == 2) y4[0] = 1'b0;
    end
    assign y2 = ~a2;

    inv6_response_checker #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A1(a4[0]), .A2(a4[1]), .A3(a4[2]), .A4(a4[3]), .A5(a4[4]), .A6(a4[5]),
        .Y1(y4[0]), .Y2(y4[1]), .Y3(y4[2]), .Y4(y4[3]), .Y5(y4[4]), .Y6(y4[5]),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_mask(mask4)
    );

    inv6_response_checker #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .A1(a2[0]), .A2(a2[1]), .A3(a2[2]), .A4(a2[3]), .A5(a2[4]), .A6(a2[5]),
        .Y1(y2[0]), .Y2(y2[1]), .Y3(y2[2]), .Y4(y2[3]), .Y5(y2[4]), .Y6(y2[5]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_mask(mask2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on dut4 and count cycles until done. restart_at injects a
    // spurious start at that cycle; rst_at asserts reset at that cycle and
    // returns with reset still held low.
    task automatic run4(input int restart_at, input int rst_at, output int n);
        bit aborted;
        aborted = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        n = 0;
        chk("start_busy", busy4, 1'b1);
        chk("start_cleared", {pass4, err4, mask4, done4}, 32'h0);
        chk("vec0_drive", a4, 6'b000000);
        while (!done4 && n < 200 && !aborted) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (n == restart_at);
            if (n == 6)  chk("vec1_drive", a4, 6'b000001);
            if (n == 18) chk("vec3_drive", a4, 6'b000111);
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_async", {a4, busy4, done4, pass4, err4, mask4}, 32'h0);
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            chk("done_reached", done4, 1'b1);
            chk("busy_done_excl", busy4, 1'b0);
            chk("done_a_hold", a4, 6'b111111);
        end
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        fault  = 0;
        repeat (3) @(negedge clk);
        chk("rst_a",    a4,    6'b0);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_done", done4, 1'b0);
        chk("rst_pass", pass4, 1'b0);
        chk("rst_err",  err4,  3'd0);
        chk("rst_mask", mask4, 6'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal inverter
        run4(-1, -1, n);
        chk("ideal_latency", n, 42);
        chk("ideal_pass", pass4, 1'b1);
        chk("ideal_err",  err4,  3'd0);
        chk("ideal_mask", mask4, 6'b000000);

        // Y3 stuck at 1: vectors 3..6 drive A3=1 and expect Y3=0
        fault = 1;
        run4(-1, -1, n);
        chk("y3s1_latency", n, 42);
        chk("y3s1_err",  err4,  3'd4);
        chk("y3s1_mask", mask4, 6'b000100);
        chk("y3s1_pass", pass4, 1'b0);

        // Y1 stuck at 0: only vector 0 expects Y1=1
        fault = 2;
        run4(-1, -1, n);
        chk("y1s0_latency", n, 42);
        chk("y1s0_err",  err4,  3'd1);
        chk("y1s0_mask", mask4, 6'b000001);
        chk("y1s0_pass", pass4, 1'b0);

        // Start while busy is ignored; start in DONE reruns from scratch
        fault = 0;
        run4(10, -1, n);
        chk("busy_start_latency", n, 42);
        chk("busy_start_pass", pass4, 1'b1);
        chk("busy_start_err",  err4,  3'd0);
        run4(-1, -1, n);
        chk("rerun_latency", n, 42);
        chk("rerun_pass", pass4, 1'b1);

        // Reset in SETTLE of vector 3 with partial errors already recorded
        fault = 2;
        run4(-1, 20, n);
        repeat (2) @(negedge clk);
        chk("rst_hold_state", {busy4, done4, err4, mask4}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", {busy4, done4}, 2'b00);
        run4(-1, -1, n);
        chk("post_rst_latency", n, 42);
        chk("post_rst_err",  err4,  3'd1);
        chk("post_rst_mask", mask4, 6'b000001);
        chk("post_rst_pass", pass4, 1'b0);

        // Minimum settle time
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        @(negedge clk) start2 = 1'b0;
        n = 0;
        while (!done2 && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("s2_latency", n, 28);
        chk("s2_done", done2, 1'b1);
        chk("s2_pass", pass2, 1'b1);
        chk("s2_err",  err2,  3'd0);
        chk("s2_mask", mask2, 6'b000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv6_response_checker.md
INV6_RESPONSE_CHECKER -- requirements
Module: inv6_response_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, is the number of wait cycles between driving a vector and sampling the response; legal range 2..15.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to run the full test sequence.
REQ-005 A1..A6  output  1 each  stimulus driven to the hex-inverter inputs.
REQ-006 Y1..Y6  input  1 each  hex-inverter outputs under test; asynchronous to clk.
REQ-007 busy  output  1  high while a sequence runs.
REQ-008 done  output  1  high from sequence end until the next accepted start.
REQ-009 pass  output  1  valid while done is high: 1 = every vector matched.
REQ-010 err_count  output  3  number of vectors with at least one mismatching bit.
REQ-011 fail_mask  output  6  bit i-1 set if Yi mismatched on any vector.

Function
REQ-012 Vector set is 7 entries, indexed 0..6; vector k has A1..Ak = 1 and the rest = 0 (000000, 000001, 000011 ... 111111, bit 0 = A1).
REQ-013 Y1..Y6 pass through a 2-flop synchronizer before any comparison.
REQ-014 States are IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE or DONE with start=1 -> DRIVE, with vector index 0 and err_count, fail_mask and pass cleared on the same edge.
REQ-016 DRIVE lasts 1 cycle; A1..A6 are registered to the current vector on entry to DRIVE.
REQ-017 SETTLE lasts exactly SETTLE_CYCLES cycles, counted by a 4-bit counter; A1..A6 are held.
REQ-018 SAMPLE lasts 1 cycle: mismatch = synced {Y6..Y1} XOR NOT(vector); fail_mask |= mismatch; err_count increments by 1 if mismatch is nonzero.
REQ-019 From SAMPLE: if index < 6 -> DRIVE with index+1; if index = 6 -> DONE.
REQ-020 Per-vector cost is SETTLE_CYCLES+2 cycles; done rises 7*(SETTLE_CYCLES+2) cycles after the edge that samples start.
REQ-021 pass = (err_count == 0), registered on entry to DONE.
REQ-022 busy = 1 in DRIVE, SETTLE and SAMPLE; done = 1 only in DONE; busy and done are never high together.
REQ-023 start while busy is ignored and has no side effects.
REQ-024 err_count cannot exceed 7 and needs no saturation.
REQ-025 In IDLE, A1..A6 = 0; in DONE, A1..A6 hold 111111 until the next start.

Reset
REQ-026 rst_n low forces, asynchronously: state IDLE, A1..A6 = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_mask = 0, counters = 0, synchronizer flops = 0.
REQ-027 Reset during any state aborts the sequence with no partial results retained; the first start after release begins a full sequence.

Structure
REQ-028 A shared package holds the state enum, NUM_VECTORS = 7 and VEC_W = 6.
REQ-029 A single sub-module, sync2_bus (parameterized width, 2 flops, async active-low reset), provides the synchronizer.
REQ-030 Vector generation is combinational from the index: thermometer code of width 6.

Verification
REQ-031 Ideal inverter model (Y = ~A, zero delay), SETTLE_CYCLES=4, pulse start -> done high exactly 42 cycles later, pass=1, err_count=0, fail_mask=000000.
REQ-032 Y3 stuck at 1 -> vectors 3..6 mismatch: err_count=4, fail_mask=000100, pass=0.
REQ-033 Y1 stuck at 0 -> only vector 0 mismatches: err_count=1, fail_mask=000001, pass=0.
REQ-034 start pulsed again at cycle 10 of a run -> ignored; done still at cycle 42; a second start in DONE clears the results and reruns, done again 42 cycles later.
REQ-035 rst_n pulsed low during SETTLE of vector 3 -> all outputs zero immediately; after release and a new start, a full 7-vector run completes with the correct result.
REQ-036 SETTLE_CYCLES=2 with the ideal model -> done at cycle 28, pass=1; confirms the minimum settle still covers the synchronizer latency.
